// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared widths, state encoding and counter-width helper for the truth-table sweeper
package tt_sweep_pkg;

  localparam int N_IN_DEF        = 3;
  localparam int N_OUT_DEF       = 3;
  localparam int HOLD_CYCLES_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One extra bit so HOLD_CYCLES-1 always fits, including HOLD_CYCLES == 1.
  function automatic int cnt_width(input int hold);
    return $clog2(hold) + 1;
  endfunction

endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// rtl/tt_sweep_ctrl_if.sv - host/unit-facing bundle of the sweep controller
interface tt_sweep_ctrl_if
  import tt_sweep_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF
);

  logic             start;
  logic [N_IN-1:0]  stim;
  logic [N_OUT-1:0] resp;
  logic             busy;
  logic             done;
  logic [N_IN-1:0]  rd_addr;
  logic [N_OUT-1:0] rd_data;
  logic [N_OUT-1:0] sig;

  modport master (
    output start, resp, rd_addr,
    input  stim, busy, done, rd_data, sig
  );

  modport slave (
    input  start, resp, rd_addr,
    output stim, busy, done, rd_data, sig
  );

endinterface

// File: rtl/tt_hold_timer.sv
// rtl/tt_hold_timer.sv - hold-window counter; last_o marks the final cycle of each window
module tt_hold_timer
  import tt_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam int CW = cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  assign last_o = (count_q == LAST);

  // Wraps to zero on the last cycle so consecutive windows need no reload.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = last_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// rtl/tt_sweep_ctrl.sv - truth-table sweep stimulus/capture stage; TT_SWEEP_SIGNATURE_EN adds XOR response signature
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int N_IN        = N_IN_DEF,
  parameter int N_OUT       = N_OUT_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input logic           clk,
  input logic           rst,
  tt_sweep_ctrl_if.slave bus
);

  localparam int NVEC = 2 ** N_IN;
  localparam logic [N_IN:0] LAST_VEC = (N_IN + 1)'(NVEC - 1);

  state_e           state_q;
  logic [N_IN:0]    vec_q;
  logic [N_IN-1:0]  stim_q;
  logic             busy_q;
  logic             done_q;
  logic [N_OUT-1:0] table_q [NVEC];
  logic             win_last;

  tt_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q != DRIVE),
    .en_i   (state_q == DRIVE),
    .last_o (win_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NVEC; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          stim_q <= '0;
          busy_q <= 1'b0;
          if (bus.start) begin
            state_q <= DRIVE;
            vec_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        DRIVE: begin
          if (win_last) begin
            table_q[vec_q[N_IN-1:0]] <= bus.resp;
            if (vec_q == LAST_VEC) begin
              state_q <= DONE;
              stim_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              vec_q  <= vec_q + 1'b1;
              stim_q <= stim_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          stim_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stim    = stim_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_data = table_q[bus.rd_addr];

`ifdef TT_SWEEP_SIGNATURE_EN
  logic [N_OUT-1:0] sig_q;

  // Accumulates on exactly the edges that write the table.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else if (state_q == IDLE && bus.start) begin
      sig_q <= '0;
    end else if (state_q == DRIVE && win_last) begin
      sig_q <= sig_q ^ bus.resp;
    end
  end

  assign bus.sig = sig_q;
`else
  assign bus.sig = '0;
`endif

endmodule
